// File: rtl/sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// sobel_window_buffer : raster-stream 3x3 window generator with two line buffers
// Optional feature macro: SOBEL_WIN_POS_EN (adds win_col_o / win_row_o)
// Revision: 1.0
// ============================================================================
module sobel_window_buffer #(
  parameter int PX_W       = 8,
  parameter int LINE_LEN   = 16,
  parameter int FRAME_ROWS = 16
) (
  input  logic                clk_i,
  input  logic                nreset_i,
  input  logic                frame_start_i,
  input  logic                px_valid_i,
  input  logic [PX_W-1:0]     px_i,
  output logic                win_valid_o,
  output logic [9*PX_W-1:0]   win_o,
`ifdef SOBEL_WIN_POS_EN
  output logic [7:0]          win_col_o,
  output logic [7:0]          win_row_o,
`endif
  output logic                frame_done_o
);

  localparam int CW = (LINE_LEN   > 2) ? $clog2(LINE_LEN)   : 1;
  localparam int RW = (FRAME_ROWS > 2) ? $clog2(FRAME_ROWS) : 1;
  localparam logic [CW-1:0] C_COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(FRAME_ROWS - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PX_W-1:0] win_q [9];
  logic [PX_W-1:0] win_d [9];
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  logic [PX_W-1:0] lb0_q [LINE_LEN];
  logic [PX_W-1:0] lb1_q [LINE_LEN];

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [PX_W-1:0] w_top;
  logic [PX_W-1:0] w_mid;

  // frame_start_i restarts the position in the same cycle, so an accompanying
  // pixel is already treated as (0,0) of the new frame.
  assign w_col = frame_start_i ? '0 : col_q;
  assign w_row = frame_start_i ? '0 : row_q;
  assign w_top = lb1_q[w_col];
  assign w_mid = lb0_q[w_col];

  always_comb begin
    col_d        = w_col;
    row_d        = w_row;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (px_valid_i) begin
      if (w_col == C_COL_LAST) begin
        col_d = '0;
        row_d = (w_row == C_ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        col_d = w_col + 1'b1;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = w_top;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = w_mid;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = px_i;
      win_valid_d  = (w_row >= C_ROW_TWO) && (w_col >= C_COL_TWO);
      frame_done_d = (w_row == C_ROW_LAST) && (w_col == C_COL_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers carry no reset; stale contents are never flagged valid.
  always_ff @(posedge clk_i) begin
    if (px_valid_i) begin
      lb1_q[w_col] <= lb0_q[w_col];
      lb0_q[w_col] <= px_i;
    end
  end

`ifdef SOBEL_WIN_POS_EN
  logic [7:0] win_col_q, win_col_d;
  logic [7:0] win_row_q, win_row_d;

  always_comb begin
    win_col_d = win_col_q;
    win_row_d = win_row_q;
    if (px_valid_i) begin
      win_col_d = 8'(w_col) - 8'd1;
      win_row_d = 8'(w_row) - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      win_col_q <= '0;
      win_row_q <= '0;
    end else begin
      win_col_q <= win_col_d;
      win_row_q <= win_row_d;
    end
  end

  assign win_col_o = win_col_q;
  assign win_row_o = win_row_q;
`endif

  generate
    for (genvar k = 0; k < 9; k++) begin : g_pack
      assign win_o[PX_W*k +: PX_W] = win_q[k];
    end
  endgenerate

  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// tb_sobel_window_buffer : directed self-checking bench, 4x4 frames of 8-bit pixels
// Revision: 1.0
// ============================================================================
module tb_sobel_window_buffer;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        px_valid_i = 1'b0;
  logic [7:0]  px_i = '0;
  logic        win_valid_o;
  logic [71:0] win_o;
  logic        frame_done_o;
`ifdef SOBEL_WIN_POS_EN
  logic [7:0]  win_col_o;
  logic [7:0]  win_row_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mr = 0;
  int mc = 0;
  int pulses = 0;
  logic [71:0] last_win = '0;
  logic        last_valid = 1'b0;

  sobel_window_buffer #(.PX_W(8), .LINE_LEN(4), .FRAME_ROWS(4)) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .frame_start_i(frame_start_i),
    .px_valid_i   (px_valid_i),
    .px_i         (px_i),
    .win_valid_o  (win_valid_o),
    .win_o        (win_o),
`ifdef SOBEL_WIN_POS_EN
    .win_col_o    (win_col_o),
    .win_row_o    (win_row_o),
`endif
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 3x3 window whose newest pixel sits at (r,c) of a frame whose pixel
  // (y,x) has value b + 4*y + x.
  function automatic logic [71:0] ewin(input int b, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[8*k +: 8] = 8'(b + 4*(r - 2 + k/3) + (c - 2 + k%3));
    end
    return w;
  endfunction

  task automatic drive(input logic v, input logic fs, input logic [7:0] p);
    @(negedge clk_i);
    px_valid_i    = v;
    frame_start_i = fs;
    px_i          = p;
    @(posedge clk_i);
    #1;
    px_valid_i    = 1'b0;
    frame_start_i = 1'b0;
  endtask

  task automatic push(input int base, input logic fs);
    logic ev;
    logic ed;
    if (fs) begin
      mr = 0;
      mc = 0;
    end
    ev = (mr >= 2) && (mc >= 2);
    ed = (mr == 3) && (mc == 3);
    drive(1'b1, fs, 8'(base + 4*mr + mc));
    chk($sformatf("valid(%0d,%0d)", mr, mc), 72'(win_valid_o), 72'(ev));
    chk($sformatf("done(%0d,%0d)", mr, mc), 72'(frame_done_o), 72'(ed));
    last_valid = ev;
    if (ev) begin
      pulses++;
      last_win = ewin(base, mr, mc);
      chk($sformatf("win(%0d,%0d)", mr, mc), win_o, last_win);
`ifdef SOBEL_WIN_POS_EN
      chk("win_col", 72'(win_col_o), 72'(mc - 1));
      chk("win_row", 72'(win_row_o), 72'(mr - 1));
`endif
    end
    mc++;
    if (mc == 4) begin
      mc = 0;
      mr = (mr == 3) ? 0 : mr + 1;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'hEE);
    chk("idle_valid", 72'(win_valid_o), 72'd0);
    chk("idle_done", 72'(frame_done_o), 72'd0);
    if (last_valid) chk("idle_hold_win", win_o, last_win);
  endtask

  task automatic frame(input int base, input int n, input logic gaps);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      push(base, 1'b0);
      if (gaps) idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 72'(win_valid_o), 72'd0);
    chk("rst_done", 72'(frame_done_o), 72'd0);
    chk("rst_win", win_o, 72'd0);
    @(negedge clk_i);
    nreset_i = 1'b1;

    // Back-to-back frame 1..16
    frame(1, 16, 1'b0);
    chk("pulses_b2b", 72'(pulses), 72'd4);
    chk("last_win_b2b", win_o, ewin(1, 3, 3));

    // Same frame with an idle cycle after every pixel
    frame(1, 16, 1'b1);
    chk("pulses_gaps", 72'(pulses), 72'd4);

    // Abort after pixel 7, restart with a lone frame_start, then 101..116
    frame(1, 7, 1'b0);
    drive(1'b0, 1'b1, 8'h00);
    mr = 0;
    mc = 0;
    chk("fs_valid", 72'(win_valid_o), 72'd0);
    chk("fs_done", 72'(frame_done_o), 72'd0);
    frame(101, 16, 1'b0);
    chk("pulses_after_abort", 72'(pulses), 72'd4);

    // Abort after pixel 15; frame_start coincides with the new frame's first pixel
    frame(1, 15, 1'b0);
    chk("pulses_partial", 72'(pulses), 72'd3);
    pulses = 0;
    push(201, 1'b1);
    for (int i = 1; i < 16; i++) push(201, 1'b0);
    chk("pulses_fs_with_px", 72'(pulses), 72'd4);

    // Asynchronous reset mid-frame
    frame(1, 11, 1'b0);
    chk("pre_rst_valid", 72'(win_valid_o), 72'd1);
    @(negedge clk_i);
    nreset_i = 1'b0;
    #1;
    chk("async_rst_valid", 72'(win_valid_o), 72'd0);
    chk("async_rst_done", 72'(frame_done_o), 72'd0);
    chk("async_rst_win", win_o, 72'd0);
`ifdef SOBEL_WIN_POS_EN
    chk("async_rst_col", 72'(win_col_o), 72'd0);
    chk("async_rst_row", 72'(win_row_o), 72'd0);
`endif
    @(negedge clk_i);
    nreset_i = 1'b1;
    mr = 0;
    mc = 0;
    last_valid = 1'b0;
    frame(51, 16, 1'b0);
    chk("pulses_after_rst", 72'(pulses), 72'd4);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
